// File: rtl/choice_select_pkg.sv
// Shared types and constants for the button-driven choice selector.
// Holds the FSM state enum, the index width and the default parameters,
// plus the modular step helper used by the index register.
package choice_select_pkg;

  localparam int IDX_W         = 3;
  localparam int N_CHOICES_DEF = 6;
  localparam int DB_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    BROWSE  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // One step up or down, wrapping inside 0..n-1 (never modulo 2**IDX_W).
  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx,
                                                input logic up, input int n);
    logic [IDX_W-1:0] last;
    last = IDX_W'(n - 1);
    if (up) return (idx == last) ? '0 : idx + 1'b1;
    else    return (idx == '0) ? last : idx - 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-flop synchronizer + stability counter + registered rising-edge pulse.
// Latency: raw edge sampled at edge t -> press_o high in cycle t+DB_CYCLES+2.
// Backpressure: none; one pulse per accepted 0->1 level change, releases are silent.
// Ports: clk, rst_n (sync, active-low), btn_i (raw, async), press_o (1-cycle pulse).
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized sample disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/choice_select_ctrl.sv
// Purpose: debounced up/down/ok/back buttons drive a wrapping choice index with confirm/lock.
// Latency: index/state update visible at edge t+DB_CYCLES+3 after raw edge sampled at t.
// Backpressure: none; each press pulse is one action, presses in CONFIRM or ignored states drop.
// Ports: clk, rst_n (sync, active-low), btn_up/btn_down/btn_ok/btn_back (raw),
//        index (browse value), chosen (last confirmed), chosen_valid (pulse), locked.
module choice_select_ctrl
  import choice_select_pkg::*;
#(
  parameter int N_CHOICES = N_CHOICES_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_ok,
  input  logic             btn_back,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] chosen,
  output logic             chosen_valid,
  output logic             locked
);

  logic press_up, press_down, press_ok, press_back;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_up), .press_o(press_up));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_down), .press_o(press_down));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ok (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_ok), .press_o(press_ok));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_back (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_back), .press_o(press_back));

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] chosen_q, chosen_d;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    chosen_d = chosen_q;
    case (state_q)
      BROWSE: begin
        // Priority ok > back > up/down; simultaneous up+down cancel out.
        if (press_ok) begin
          state_d = CONFIRM;
        end else if (press_back) begin
          index_d = '0;
        end else if (press_up ^ press_down) begin
          index_d = idx_step(index_q, press_up, N_CHOICES);
        end
      end
      CONFIRM: begin
        chosen_d = index_q;
        state_d  = LOCKED;
      end
      LOCKED: begin
        if (press_back) state_d = BROWSE;
      end
      default: state_d = BROWSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BROWSE;
      index_q  <= '0;
      chosen_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      chosen_q <= chosen_d;
    end
  end

  assign index        = index_q;
  assign chosen       = chosen_q;
  assign chosen_valid = (state_q == CONFIRM);
  assign locked       = (state_q == LOCKED);

endmodule
